// File: rtl/leaf_pe_adapter_pkg.sv
// Shared flit-format definitions for the B-tree NoC leaf adapters and switches.
// A flit is {dest[AddrWidth-1:0], payload[DataWidth-AddrWidth-1:0]}.
package leaf_pe_adapter_pkg;

    localparam int DEF_DATA_WIDTH = 36;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int flitDestMsb(input int dataWidth);
        return dataWidth - 1;
    endfunction

    function automatic int payloadWidth(input int dataWidth, input int addrWidth);
        return dataWidth - addrWidth;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with the head presented straight from storage and full/empty flags.
// Push while full is honoured only when a pop frees the head slot in the same cycle.
module noc_sync_fifo #(
    parameter int Width = 36,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic [Width-1:0] pushData,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic [CntW-1:0]  count;
    logic             doPush;
    logic             doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    assign full  = (count == CntW'(Depth));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leaf_pe_adapter.sv
// PE-side network interface for one leaf port of the B-tree NoC: packs/unpacks flits,
// buffers both directions, loops self-addressed traffic back and drops misrouted flits.
module leaf_pe_adapter
    import leaf_pe_adapter_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int AddrWidth = DEF_ADDR_WIDTH,
    parameter int MyAddr    = 0,
    parameter int FifoDepth = DEF_FIFO_DEPTH
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_tx_payload,
    input  logic [AddrWidth-1:0]           i_pe_tx_dest,
    input  logic                           i_pe_tx_valid,
    output logic                           o_pe_tx_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_rx_payload,
    output logic                           o_pe_rx_valid,
    input  logic                           i_pe_rx_ready,
    output logic [DataWidth-1:0]           o_net_data,
    output logic                           o_net_data_valid,
    input  logic                           i_net_data_ready,
    input  logic [DataWidth-1:0]           i_net_data,
    input  logic                           i_net_data_valid,
    output logic                           o_net_data_ready,
    output logic [15:0]                    o_tx_count,
    output logic [15:0]                    o_rx_count,
    output logic [7:0]                     o_err_count
);

    localparam int PayloadWidth = payloadWidth(DataWidth, AddrWidth);
    localparam int DestMsb      = flitDestMsb(DataWidth);
    localparam logic [AddrWidth-1:0] MyAddrBits = AddrWidth'(MyAddr);

    // Every channel moves a word on a cycle where valid && ready; a source keeps its
    // data stable while valid && !ready and never drops valid before the transfer.

    logic [AddrWidth-1:0]    inDest;
    logic                    inForMe;
    logic                    netAccept;
    logic                    netWrite;
    logic                    netDrop;
    logic                    txLoop;
    logic                    peAccept;
    logic                    txPush;
    logic                    rxPush;
    logic [PayloadWidth-1:0] rxPushData;
    logic                    txFull;
    logic                    txEmpty;
    logic                    rxFull;
    logic                    rxEmpty;
    logic [15:0]             txCount;
    logic [15:0]             rxCount;
    logic [7:0]              errCount;

    assign inDest  = i_net_data[DestMsb -: AddrWidth];
    assign inForMe = (inDest == MyAddrBits);
    assign txLoop  = (i_pe_tx_dest == MyAddrBits);

    // Misrouted flits never need RX space, so they are always drained.
    assign o_net_data_ready = !rxFull || !inForMe;
    assign netAccept        = i_net_data_valid && o_net_data_ready;
    assign netWrite         = netAccept && inForMe;
    assign netDrop          = netAccept && !inForMe;

    // Loopback yields the single RX write port to any inbound flit addressed to us.
    assign o_pe_tx_ready = txLoop ? (!rxFull && !(i_net_data_valid && inForMe)) : !txFull;
    assign peAccept      = i_pe_tx_valid && o_pe_tx_ready;
    assign txPush        = peAccept && !txLoop;

    assign rxPush     = netWrite || (peAccept && txLoop);
    assign rxPushData = netWrite ? i_net_data[PayloadWidth-1:0] : i_pe_tx_payload;

    noc_sync_fifo #(
        .Width(DataWidth),
        .Depth(FifoDepth)
    ) txFifo (
        .clk     (i_clk),
        .resetN  (i_reset),
        .push    (txPush),
        .pushData({i_pe_tx_dest, i_pe_tx_payload}),
        .pop     (i_net_data_ready),
        .head    (o_net_data),
        .full    (txFull),
        .empty   (txEmpty)
    );

    noc_sync_fifo #(
        .Width(PayloadWidth),
        .Depth(FifoDepth)
    ) rxFifo (
        .clk     (i_clk),
        .resetN  (i_reset),
        .push    (rxPush),
        .pushData(rxPushData),
        .pop     (i_pe_rx_ready),
        .head    (o_pe_rx_payload),
        .full    (rxFull),
        .empty   (rxEmpty)
    );

    assign o_net_data_valid = !txEmpty;
    assign o_pe_rx_valid    = !rxEmpty;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            txCount  <= '0;
            rxCount  <= '0;
            errCount <= '0;
        end else begin
            if (o_net_data_valid && i_net_data_ready) begin
                txCount <= txCount + 16'd1;
            end
            if (rxPush) begin
                rxCount <= rxCount + 16'd1;
            end
            if (netDrop && (errCount != 8'hFF)) begin
                errCount <= errCount + 8'd1;
            end
        end
    end

    assign o_tx_count  = txCount;
    assign o_rx_count  = rxCount;
    assign o_err_count = errCount;

endmodule
